// File: rtl/apple_spawner_if.sv
// Bundle between the apple spawner, the snake movement logic and the renderer.
// The snake/renderer side uses the master modport; the spawner uses the slave modport.
`timescale 1ns/1ps
interface apple_spawner_if #(
  parameter int X_W        = 6,
  parameter int Y_W        = 5,
  parameter int NUM_APPLES = 2
);
  logic [X_W-1:0]            head_x;
  logic [Y_W-1:0]            head_y;
  logic [NUM_APPLES*X_W-1:0] apple_x;
  logic [NUM_APPLES*Y_W-1:0] apple_y;
  logic [NUM_APPLES-1:0]     apple_valid;
  logic                      add_cube;
  logic [15:0]               eaten_cnt;

  modport master (
    output head_x, head_y,
    input  apple_x, apple_y, apple_valid, add_cube, eaten_cnt
  );

  modport slave (
    input  head_x, head_y,
    output apple_x, apple_y, apple_valid, add_cube, eaten_cnt
  );
endinterface

// File: rtl/apple_spawner.sv
// Snake-game apple manager: on each game tick it checks the head against every live
// apple, pulses add_cube on an eat and relocates that apple to a random free cell.
`timescale 1ns/1ps
module apple_spawner #(
  parameter int          X_W        = 6,
  parameter int          Y_W        = 5,
  parameter int          NUM_APPLES = 2,
  parameter int          X_MIN      = 1,
  parameter int          X_MAX      = 38,
  parameter int          Y_MIN      = 1,
  parameter int          Y_MAX      = 28,
  parameter int          INIT_X     = 24,
  parameter int          INIT_Y     = 10,
  parameter int          TICK_DIV   = 250000,
  parameter int          MAX_TRIES  = 15,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input logic             clk,
  input logic             reset,
  apple_spawner_if.slave  bus_if
);

  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW  = $clog2(MAX_TRIES + 1);
  localparam int KW  = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1;

  localparam logic [15:0]    SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [X_W-1:0] X_MIN_C   = X_W'(X_MIN);
  localparam logic [X_W-1:0] X_MAX_C   = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_MIN_C   = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0] Y_MAX_C   = Y_W'(Y_MAX);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
  localparam logic [TW-1:0]  TRIES_C   = TW'(MAX_TRIES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHECK    = 2'd1,
    ST_DRAW     = 2'd2,
    ST_VALIDATE = 2'd3
  } state_e;

  function automatic logic [NUM_APPLES*X_W-1:0] init_x_vec();
    logic [NUM_APPLES*X_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_APPLES; i++) begin
      v[i*X_W +: X_W] = X_W'(INIT_X + 2 * i);
    end
    return v;
  endfunction

  function automatic logic [NUM_APPLES*Y_W-1:0] init_y_vec();
    logic [NUM_APPLES*Y_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_APPLES; i++) begin
      v[i*Y_W +: Y_W] = Y_W'(INIT_Y);
    end
    return v;
  endfunction

  state_e                    state_q, state_d;
  logic [TCW-1:0]            tick_cnt_q;
  logic [15:0]               lfsr_q;
  logic [NUM_APPLES*X_W-1:0] apple_x_q;
  logic [NUM_APPLES*Y_W-1:0] apple_y_q;
  logic [NUM_APPLES-1:0]     valid_q;
  logic                      add_cube_q;
  logic [15:0]               eaten_q;
  logic [TW-1:0]             try_q;
  logic [KW-1:0]             k_q;
  logic [X_W-1:0]            cand_x_q;
  logic [Y_W-1:0]            cand_y_q;

  logic                  tick_s;
  logic [NUM_APPLES-1:0] match_s;
  logic                  hit_s;
  logic [KW-1:0]         hit_idx_s;
  logic                  collide_s;
  logic                  accept_s;
  logic [TW-1:0]         try_inc_s;
  logic                  do_hit_s;
  logic                  do_accept_s;
  logic                  do_reject_s;
  logic                  do_fallback_s;

  assign tick_s    = (tick_cnt_q == TICK_LAST);
  assign try_inc_s = try_q + TW'(1);

  // Game-tick divider, free running outside reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (tick_s) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TCW'(1);
    end
  end

  // Fibonacci LFSR, taps 16,14,13,11; advances every clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // Head-vs-apple match; the lowest matching live index wins.
  always_comb begin
    match_s   = '0;
    hit_idx_s = '0;
    for (int i = NUM_APPLES - 1; i >= 0; i--) begin
      match_s[i] = valid_q[i] &&
                   (apple_x_q[i*X_W +: X_W] == bus_if.head_x) &&
                   (apple_y_q[i*Y_W +: Y_W] == bus_if.head_y);
      hit_idx_s  = match_s[i] ? KW'(i) : hit_idx_s;
    end
    hit_s = |match_s;
  end

  // Candidate acceptance: in bounds, off the head, off every other live apple.
  always_comb begin
    collide_s = 1'b0;
    for (int j = 0; j < NUM_APPLES; j++) begin
      collide_s = collide_s | (valid_q[j] && (KW'(j) != k_q) &&
                               (apple_x_q[j*X_W +: X_W] == cand_x_q) &&
                               (apple_y_q[j*Y_W +: Y_W] == cand_y_q));
    end
    accept_s = (cand_x_q >= X_MIN_C) && (cand_x_q <= X_MAX_C) &&
               (cand_y_q >= Y_MIN_C) && (cand_y_q <= Y_MAX_C) &&
               !((cand_x_q == bus_if.head_x) && (cand_y_q == bus_if.head_y)) &&
               !collide_s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and datapath strobes; ticks outside IDLE are simply ignored.
  always_comb begin
    state_d       = state_q;
    do_hit_s      = 1'b0;
    do_accept_s   = 1'b0;
    do_reject_s   = 1'b0;
    do_fallback_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick_s) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (hit_s) begin
          do_hit_s = 1'b1;
          state_d  = ST_DRAW;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_DRAW: begin
        state_d = ST_VALIDATE;
      end
      ST_VALIDATE: begin
        if (accept_s) begin
          do_accept_s   = 1'b1;
          state_d       = ST_IDLE;
        end else if (try_inc_s < TRIES_C) begin
          do_reject_s   = 1'b1;
          state_d       = ST_DRAW;
        end else begin
          do_fallback_s = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Apple table, eat pulse/counter and respawn bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      apple_x_q  <= init_x_vec();
      apple_y_q  <= init_y_vec();
      valid_q    <= '1;
      add_cube_q <= 1'b0;
      eaten_q    <= 16'h0000;
      try_q      <= '0;
      k_q        <= '0;
      cand_x_q   <= '0;
      cand_y_q   <= '0;
    end else begin
      add_cube_q <= do_hit_s;
      if (do_hit_s) begin
        valid_q[hit_idx_s] <= 1'b0;
        eaten_q            <= eaten_q + 16'h0001;
        try_q              <= '0;
        k_q                <= hit_idx_s;
      end
      if (state_q == ST_DRAW) begin
        cand_x_q <= lfsr_q[X_W-1:0];
        cand_y_q <= lfsr_q[X_W+Y_W-1:X_W];
      end
      if (do_reject_s || do_fallback_s) begin
        try_q <= try_inc_s;
      end
      if (do_accept_s) begin
        apple_x_q[int'(k_q)*X_W +: X_W] <= cand_x_q;
        apple_y_q[int'(k_q)*Y_W +: Y_W] <= cand_y_q;
        valid_q[k_q]                    <= 1'b1;
      end
      // Fallback cell is deliberately not collision-checked.
      if (do_fallback_s) begin
        apple_x_q[int'(k_q)*X_W +: X_W] <= X_MIN_C + X_W'(k_q);
        apple_y_q[int'(k_q)*Y_W +: Y_W] <= Y_MIN_C;
        valid_q[k_q]                    <= 1'b1;
      end
    end
  end

  assign bus_if.apple_x     = apple_x_q;
  assign bus_if.apple_y     = apple_y_q;
  assign bus_if.apple_valid = valid_q;
  assign bus_if.add_cube    = add_cube_q;
  assign bus_if.eaten_cnt   = eaten_q;

endmodule
